// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Pops bytes from the UART RX FIFO, hunts for SOF, then parses
//            LEN + payload + XOR checksum. It buffers the payload and releases
//            it on a valid/ready stream only after the checksum matches.
//            Bad frames are dropped and reported as one-cycle error pulses.
// Options  : define UART_FRAME_TIMEOUT_EN to enable the inter-byte timeout.
// Revision : 1.0  initial release
// ============================================================================
module uart_frame_parser #(
   parameter logic [7:0] SOF_BYTE       = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         LEN_WIDTH      = 5,
   parameter int         TIMEOUT_CYCLES = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  fifo_dout_i,
   input  logic        fifo_empty_i,
   output logic        fifo_rd_en_o,
   output logic [7:0]  m_data_o,
   output logic        m_valid_o,
   output logic        m_last_o,
   input  logic        m_ready_i,
   output logic        frame_ok_o,
   output logic        err_len_o,
   output logic        err_chk_o,
   output logic        err_timeout_o,
   output logic [15:0] frame_cnt_o
);

   localparam int                   BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]           MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

   // Catch inconsistent parameter sets at elaboration time
   generate
      if (LEN_WIDTH != $clog2(MAX_LEN + 1) || TIMEOUT_CYCLES < 1 || MAX_LEN > 255) begin : g_param_check
         $error("uart_frame_parser: inconsistent LEN_WIDTH/MAX_LEN/TIMEOUT_CYCLES");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_HUNT  = 3'd0,
      S_LEN   = 3'd1,
      S_PAY   = 3'd2,
      S_CHK   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 rd_pend_q, rd_pend_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] idx_q, idx_d;
   logic [LEN_WIDTH-1:0] rd_idx_q, rd_idx_d;
   logic [7:0]           chk_q, chk_d;
   logic [7:0]           buf_q [MAX_LEN];
   logic [7:0]           buf_d [MAX_LEN];
   logic                 frame_ok_q, frame_ok_d;
   logic                 err_len_q, err_len_d;
   logic                 err_chk_q, err_chk_d;
   logic                 err_timeout_q, err_timeout_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;

   logic                 rd_en;
   logic                 timeout_hit;
   logic                 drain_last;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             timed;

   // Inter-byte timer: idles at zero outside the frame body and while a byte is in flight
   always_comb begin
      tmr_d       = tmr_q;
      timeout_hit = 1'b0;
      timed       = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);
      if (!timed || rd_pend_q) begin
         tmr_d = '0;
      end else if (tmr_q == TMR_LAST) begin
         timeout_hit = 1'b1;
         tmr_d       = '0;
      end else begin
         tmr_d = tmr_q + TMR_ONE;
      end
   end

   // Timer register
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Pop only while parsing; a timeout abandons the frame so it suppresses a new read
   assign rd_en      = (state_q != S_DRAIN) && !fifo_empty_i && !rd_pend_q && !timeout_hit;
   assign drain_last = (rd_idx_q == (len_q - LEN_ONE));

   // Next-state logic: one parser transition per sampled byte, plus the drain handshake
   always_comb begin
      state_d       = state_q;
      rd_pend_d     = rd_en;
      len_d         = len_q;
      idx_d         = idx_q;
      rd_idx_d      = rd_idx_q;
      chk_d         = chk_q;
      buf_d         = buf_q;
      frame_ok_d    = 1'b0;
      err_len_d     = 1'b0;
      err_chk_d     = 1'b0;
      err_timeout_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;

      if (timeout_hit) begin
         err_timeout_d = 1'b1;
         state_d       = S_HUNT;
      end else begin
         case (state_q)
            S_HUNT: begin
               if (rd_pend_q && fifo_dout_i == SOF_BYTE) begin
                  state_d = S_LEN;
               end
            end
            S_LEN: begin
               if (rd_pend_q) begin
                  if (fifo_dout_i == 8'd0 || fifo_dout_i > MAX_LEN_B) begin
                     err_len_d = 1'b1;
                     state_d   = S_HUNT;
                  end else begin
                     len_d   = fifo_dout_i[LEN_WIDTH-1:0];
                     chk_d   = fifo_dout_i;
                     idx_d   = '0;
                     state_d = S_PAY;
                  end
               end
            end
            S_PAY: begin
               if (rd_pend_q) begin
                  buf_d[idx_q[BUF_AW-1:0]] = fifo_dout_i;
                  chk_d                    = chk_q ^ fifo_dout_i;
                  idx_d                    = idx_q + LEN_ONE;
                  if (idx_q == (len_q - LEN_ONE)) begin
                     state_d = S_CHK;
                  end
               end
            end
            S_CHK: begin
               if (rd_pend_q) begin
                  if (fifo_dout_i == chk_q) begin
                     frame_ok_d  = 1'b1;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     rd_idx_d    = '0;
                     state_d     = S_DRAIN;
                  end else begin
                     err_chk_d = 1'b1;
                     state_d   = S_HUNT;
                  end
               end
            end
            S_DRAIN: begin
               if (m_ready_i) begin
                  if (drain_last) begin
                     state_d = S_HUNT;
                  end else begin
                     rd_idx_d = rd_idx_q + LEN_ONE;
                  end
               end
            end
            default: begin
               state_d = S_HUNT;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_HUNT;
         rd_pend_q     <= 1'b0;
         len_q         <= '0;
         idx_q         <= '0;
         rd_idx_q      <= '0;
         chk_q         <= '0;
         frame_ok_q    <= 1'b0;
         err_len_q     <= 1'b0;
         err_chk_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         frame_cnt_q   <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         rd_pend_q     <= rd_pend_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         rd_idx_q      <= rd_idx_d;
         chk_q         <= chk_d;
         frame_ok_q    <= frame_ok_d;
         err_len_q     <= err_len_d;
         err_chk_q     <= err_chk_d;
         err_timeout_q <= err_timeout_d;
         frame_cnt_q   <= frame_cnt_d;
         buf_q         <= buf_d;
      end
   end

   // Stream outputs come straight from registers and read as zero outside DRAIN
   assign m_valid_o     = (state_q == S_DRAIN);
   assign m_data_o      = m_valid_o ? buf_q[rd_idx_q[BUF_AW-1:0]] : 8'd0;
   assign m_last_o      = m_valid_o && drain_last;
   assign fifo_rd_en_o  = rd_en;
   assign frame_ok_o    = frame_ok_q;
   assign err_len_o     = err_len_q;
   assign err_chk_o     = err_chk_q;
   assign err_timeout_o = err_timeout_q;
   assign frame_cnt_o   = frame_cnt_q;

endmodule
`default_nettype wire
